// File: rtl/nios_system_com_ocmem_pkg.sv
// Shared constants, command payload and helpers for the two-requester
// on-chip memory arbiter.
package nios_system_com_ocmem_pkg;

    localparam int unsigned MEM_WORDS_DEF = 768;
    localparam int unsigned ADDR_W_DEF    = 10;
    localparam int unsigned DATA_W        = 32;
    localparam int unsigned BE_W          = 4;
    localparam int unsigned ERR_W         = 16;

    localparam logic REQ_M0 = 1'b0;
    localparam logic REQ_M1 = 1'b1;

    // Address-independent part of a requester command; concatenation order
    // matches {read, write, byteenable, writedata}.
    typedef struct packed {
        logic              rd;
        logic              wr;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } ocm_cmd_t;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == {ERR_W{1'b1}}) ? v : v + ERR_W'(1);
    endfunction

endpackage

// File: rtl/nios_system_com_rr_arb2.sv
// Two-input round-robin arbiter: combinational grant, registered priority
// pointer that flips to the loser after each contested grant.
module nios_system_com_rr_arb2
    import nios_system_com_ocmem_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic r_prio;

    // No grant is issued while reset is held.
    always_comb begin
        gnt = 2'b00;
        if (!reset) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (r_prio == REQ_M1) ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prio <= REQ_M0;
        end else if (req == 2'b11) begin
            r_prio <= ~r_prio;
        end
    end

endmodule

// File: rtl/nios_system_com_ocmem_arbiter.sv
// Shares one single-port on-chip memory between two Avalon-MM requesters
// with round-robin grant, one-cycle read return and out-of-range trapping.
module nios_system_com_ocmem_arbiter
    import nios_system_com_ocmem_pkg::*;
#(
    parameter int unsigned MEM_WORDS = MEM_WORDS_DEF,
    parameter int unsigned ADDR_W    = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic [3:0]        m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [31:0]       m0_writedata,
    output logic [31:0]       m0_readdata,
    output logic              m0_readdatavalid,
    output logic              m0_waitrequest,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic [3:0]        m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [31:0]       m1_writedata,
    output logic [31:0]       m1_readdata,
    output logic              m1_readdatavalid,
    output logic              m1_waitrequest,

    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              mem_clken,
    input  logic [31:0]       mem_readdata,

    output logic              err_range,
    output logic [15:0]       err_count
);

    logic [1:0]        w_active;
    logic [1:0]        w_gnt;
    logic              w_any_gnt;
    logic              w_sel;
    logic [ADDR_W-1:0] w_addr;
    ocm_cmd_t          w_cmd0;
    ocm_cmd_t          w_cmd1;
    ocm_cmd_t          w_cmd;
    logic              w_in_range;
    logic              w_rd_accept;
    logic              w_ret;

    logic              r_rd_valid;
    logic              r_rd_owner;
    logic              r_rd_oor;
    logic              r_err_range;
    logic [ERR_W-1:0]  r_err_count;

    assign w_cmd0   = {m0_read, m0_write, m0_byteenable, m0_writedata};
    assign w_cmd1   = {m1_read, m1_write, m1_byteenable, m1_writedata};
    assign w_active = {m1_read | m1_write, m0_read | m0_write};

    nios_system_com_rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (w_active),
        .gnt   (w_gnt)
    );

    assign w_any_gnt  = |w_gnt;
    assign w_sel      = w_gnt[1];
    assign w_addr     = (w_sel == REQ_M1) ? m1_address : m0_address;
    assign w_cmd      = (w_sel == REQ_M1) ? w_cmd1 : w_cmd0;
    assign w_in_range = 32'(w_addr) < 32'(MEM_WORDS);
    // A simultaneous read+write is executed as a write only.
    assign w_rd_accept = w_any_gnt & w_cmd.rd & ~w_cmd.wr;

    assign m0_waitrequest = w_active[0] & ~w_gnt[0];
    assign m1_waitrequest = w_active[1] & ~w_gnt[1];

    // Memory port: granted command forwarded, select suppressed out of range.
    always_comb begin
        mem_address    = '0;
        mem_byteenable = '0;
        mem_writedata  = '0;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        if (w_any_gnt) begin
            mem_address    = w_addr;
            mem_byteenable = w_cmd.be;
            mem_writedata  = w_cmd.wdata;
            mem_chipselect = w_in_range;
            mem_write      = w_in_range & w_cmd.wr;
        end
    end

    assign mem_clken = 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_valid  <= 1'b0;
            r_rd_owner  <= REQ_M0;
            r_rd_oor    <= 1'b0;
            r_err_range <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_rd_valid <= w_rd_accept;
            r_rd_owner <= w_sel;
            r_rd_oor   <= ~w_in_range;
            if (w_any_gnt && !w_in_range) begin
                r_err_range <= 1'b1;
                r_err_count <= sat_inc(r_err_count);
            end
        end
    end

    // Return path: only the owner sees data; out-of-range reads return zero.
    assign w_ret            = r_rd_valid & ~reset;
    assign m0_readdatavalid = w_ret & (r_rd_owner == REQ_M0);
    assign m1_readdatavalid = w_ret & (r_rd_owner == REQ_M1);
    assign m0_readdata      = (m0_readdatavalid && !r_rd_oor) ? mem_readdata : '0;
    assign m1_readdata      = (m1_readdatavalid && !r_rd_oor) ? mem_readdata : '0;

    assign err_range = r_err_range;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_nios_system_com_ocmem_arbiter.sv
// Scoreboard bench for the on-chip memory arbiter: per-requester command
// queues, a word-level reference memory and an independent return monitor.
module tb_nios_system_com_ocmem_arbiter;

    localparam int NWORDS = 768;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [9:0]  addr;
        logic [3:0]  be;
        logic [31:0] data;
    } txn_t;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  m0_address = '0, m1_address = '0;
    logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
    logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
    logic [31:0] m0_writedata = '0, m1_writedata = '0;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic        m0_waitrequest, m1_waitrequest;
    logic [9:0]  mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata = '0;
    logic        err_range;
    logic [15:0] err_count;

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;

    logic [31:0] ram     [0:1023];
    logic [31:0] ref_mem [0:1023];
    txn_t q0[$], q1[$];
    exp_t e0[$], e1[$];
    int          prio_m = 0;
    bit          err_r_m = 0;
    int          err_c_m = 0;

    always #5 clk = ~clk;

    nios_system_com_ocmem_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid), .m0_waitrequest(m0_waitrequest),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid), .m1_waitrequest(m1_waitrequest),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata),
        .err_range(err_range), .err_count(err_count)
    );

    // Synchronous single-port RAM with one-cycle read latency.
    always @(posedge clk) begin
        cyc_n <= cyc_n + 1;
        if (mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end
            mem_readdata <= ram[mem_address];
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    function automatic txn_t mk(input bit rd, input bit wr, input logic [9:0] a,
                                input logic [3:0] be, input logic [31:0] d);
        txn_t t;
        t.rd = rd; t.wr = wr; t.addr = a; t.be = be; t.data = d;
        return t;
    endfunction

    task automatic drive(input txn_t t0, input txn_t t1);
        m0_read = t0.rd; m0_write = t0.wr; m0_address = t0.addr;
        m0_byteenable = t0.be; m0_writedata = t0.data;
        m1_read = t1.rd; m1_write = t1.wr; m1_address = t1.addr;
        m1_byteenable = t1.be; m1_writedata = t1.data;
    endtask

    // Return monitor: a pulse is required exactly when the oldest expectation is due.
    always @(negedge clk) begin
        if (e0.size() > 0 && e0[0].due == cyc_n) begin
            exp_t e;
            e = e0.pop_front();
            check("m0_readdatavalid", {31'b0, m0_readdatavalid}, 32'd1);
            check("m0_readdata", m0_readdata, e.data);
        end else begin
            check("m0_readdatavalid_idle", {31'b0, m0_readdatavalid}, 32'd0);
            check("m0_readdata_idle", m0_readdata, 32'd0);
        end
        if (e1.size() > 0 && e1[0].due == cyc_n) begin
            exp_t e;
            e = e1.pop_front();
            check("m1_readdatavalid", {31'b0, m1_readdatavalid}, 32'd1);
            check("m1_readdata", m1_readdata, e.data);
        end else begin
            check("m1_readdatavalid_idle", {31'b0, m1_readdatavalid}, 32'd0);
            check("m1_readdata_idle", m1_readdata, 32'd0);
        end
    end

    // Present queue heads each cycle; the model decides who wins and what it does.
    task automatic run(input int max_cycles);
        int n = 0;
        txn_t idle;
        idle = mk(0, 0, '0, '0, '0);
        while ((q0.size() > 0 || q1.size() > 0) && n < max_cycles) begin
            txn_t t0, t1, t;
            bit a0, a1, inr;
            int g;
            t0 = (q0.size() > 0) ? q0[0] : idle;
            t1 = (q1.size() > 0) ? q1[0] : idle;
            drive(t0, t1);
            a0 = t0.rd | t0.wr;
            a1 = t1.rd | t1.wr;
            g = -1;
            if (a0 && a1) begin
                g = prio_m;
                prio_m = 1 - g;
            end else if (a0) g = 0;
            else if (a1) g = 1;
            t = (g == 1) ? t1 : t0;
            inr = (g >= 0) && (int'(t.addr) < NWORDS);
            @(negedge clk);
            check("m0_waitrequest", {31'b0, m0_waitrequest}, {31'b0, a0 && g != 0});
            check("m1_waitrequest", {31'b0, m1_waitrequest}, {31'b0, a1 && g != 1});
            check("mem_chipselect", {31'b0, mem_chipselect}, {31'b0, inr});
            check("mem_write", {31'b0, mem_write}, {31'b0, inr && t.wr});
            check("err_count", {16'b0, err_count}, err_c_m);
            check("err_range", {31'b0, err_range}, {31'b0, err_r_m});
            if (inr) check("mem_address", {22'b0, mem_address}, {22'b0, t.addr});
            if (g >= 0) begin
                if (!inr) begin
                    err_r_m = 1;
                    if (err_c_m < 65535) err_c_m++;
                end
                if (t.wr) begin
                    if (inr)
                        for (int b = 0; b < 4; b++)
                            if (t.be[b]) ref_mem[t.addr][8*b +: 8] = t.data[8*b +: 8];
                end else if (t.rd) begin
                    exp_t e;
                    e.data = inr ? ref_mem[t.addr] : 32'h0;
                    e.due  = cyc_n + 1;
                    if (g == 0) e0.push_back(e); else e1.push_back(e);
                end
            end
            if (q0.size() > 0 && (!a0 || g == 0)) void'(q0.pop_front());
            if (q1.size() > 0 && (!a1 || g == 1)) void'(q1.pop_front());
            @(posedge clk); #1;
            n++;
        end
        if (q0.size() > 0 || q1.size() > 0) begin
            check("run_timeout", 32'(q0.size() + q1.size()), 32'd0);
            q0.delete(); q1.delete();
        end
        drive(idle, idle);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("err_count_end", {16'b0, err_count}, err_c_m);
        check("err_range_end", {31'b0, err_range}, {31'b0, err_r_m});
        @(posedge clk); #1;
    endtask

    task automatic model_reset();
        prio_m = 0; err_r_m = 0; err_c_m = 0;
        e0.delete(); e1.delete();
    endtask

    initial begin
        txn_t idle;
        idle = mk(0, 0, '0, '0, '0);
        for (int i = 0; i < 1024; i++) begin
            ram[i] = '0;
            ref_mem[i] = '0;
        end

        // Power-on reset with m0 requesting: must be held off.
        drive(mk(1, 0, 10'h001, 4'hF, '0), idle);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_m0_waitrequest", {31'b0, m0_waitrequest}, 32'd1);
        check("rst_mem_chipselect", {31'b0, mem_chipselect}, 32'd0);
        check("rst_err_count", {16'b0, err_count}, 32'd0);
        @(posedge clk); #1;
        drive(idle, idle);
        reset = 1'b0;

        // Single write then read back.
        q0.push_back(mk(0, 1, 10'h005, 4'hF, 32'hDEADBEEF));
        q0.push_back(mk(1, 0, 10'h005, 4'hF, 32'h0));
        run(20);

        // Byte-enable merge.
        q0.push_back(mk(0, 1, 10'h010, 4'hF, 32'h11223344));
        q0.push_back(mk(0, 1, 10'h010, 4'b0101, 32'hAABBCCDD));
        q0.push_back(mk(1, 0, 10'h010, 4'hF, 32'h0));
        run(20);

        // Out-of-range write and read from m1.
        q1.push_back(mk(0, 1, 10'd768, 4'hF, 32'h12345678));
        q1.push_back(mk(1, 0, 10'd1023, 4'hF, 32'h0));
        run(20);

        // Read+write together behaves as a write.
        q0.push_back(mk(1, 1, 10'h020, 4'hF, 32'h5A5A5A5A));
        q0.push_back(mk(1, 0, 10'h020, 4'hF, 32'h0));
        run(20);

        // Reset one cycle after a read is accepted: its return is cancelled.
        drive(mk(1, 0, 10'h005, 4'hF, '0), idle);
        @(negedge clk);
        check("pre_rst_chipselect", {31'b0, mem_chipselect}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        model_reset();
        drive(idle, mk(1, 0, 10'h003, 4'hF, '0));
        @(negedge clk);
        check("mid_rst_m1_waitrequest", {31'b0, m1_waitrequest}, 32'd1);
        check("mid_rst_mem_chipselect", {31'b0, mem_chipselect}, 32'd0);
        check("mid_rst_mem_write", {31'b0, mem_write}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        drive(idle, idle);
        @(negedge clk);
        check("post_rst_err_count", {16'b0, err_count}, 32'd0);
        check("post_rst_err_range", {31'b0, err_range}, 32'd0);
        @(posedge clk); #1;

        // Contention: both read every cycle; prio starts at m0.
        for (int i = 0; i < 3; i++) begin
            q0.push_back(mk(1, 0, 10'(i * 16 + 5), 4'hF, '0));
            q1.push_back(mk(1, 0, 10'(i * 16), 4'hF, '0));
        end
        run(20);

        // Randomized traffic including idles, byte masks and out-of-range.
        for (int i = 0; i < 300; i++) begin
            for (int r = 0; r < 2; r++) begin
                int k;
                logic [9:0] a;
                txn_t t;
                k = int'($urandom_range(0, 9));
                a = ($urandom_range(0, 15) == 0) ? 10'(768 + $urandom_range(0, 255))
                                                 : 10'($urandom_range(0, 31));
                t = mk(k >= 2 && k <= 5, k >= 5 && k <= 8, a,
                       4'($urandom_range(0, 15)), $urandom);
                if (r == 0) q0.push_back(t); else q1.push_back(t);
            end
        end
        run(3000);

        if (e0.size() != 0 || e1.size() != 0)
            check("pending_returns", 32'(e0.size() + e1.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nios_system_com_ocmem_arbiter.md
NIOS_SYSTEM_COM_OCMEM_ARBITER -- requirements
Module: nios_system_com_ocmem_arbiter

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 768, number of implemented 32-bit words in the shared on-chip memory.
REQ-002 SHALL have parameter ADDR_W, default 10, word-address width of requesters and memory.
REQ-003 SHALL have port clk  in  1  single clock for all logic.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have, per requester n in {0,1}, ports mN_address in ADDR_W; mN_byteenable in 4; mN_read in 1; mN_write in 1; mN_writedata in 32.
REQ-006 SHALL have, per requester, ports mN_readdata out 32; mN_readdatavalid out 1; mN_waitrequest out 1 (Avalon-MM pipelined slave semantics).
REQ-007 SHALL have memory-side ports mem_address out ADDR_W; mem_byteenable out 4; mem_chipselect out 1; mem_write out 1; mem_writedata out 32; mem_clken out 1; mem_readdata in 32.
REQ-008 SHALL have status ports err_range out 1 (sticky out-of-range flag) and err_count out 16 (saturating out-of-range access count).

Function
REQ-009 SHALL drive mem_clken constant 1.
REQ-010 SHALL grant at most one requester per cycle; a requester is active when mN_read or mN_write is 1.
REQ-011 SHALL arbitrate round-robin: one active requester is granted; both active -> grant the one indicated by priority pointer prio (reset 0).
REQ-012 SHALL toggle prio to the non-granted requester after every contested grant; uncontested grants leave prio unchanged.
REQ-013 SHALL drive mN_waitrequest = active AND not granted, combinationally in the same cycle; idle requesters see waitrequest 0.
REQ-014 SHALL, for the granted requester, forward address, byteenable, writedata combinationally to mem_*; mem_chipselect = 1; mem_write = granted write.
REQ-015 SHALL treat read and write asserted together as a write; the read is discarded, no readdatavalid.
REQ-016 SHALL have fixed read latency of 1: read accepted in cycle T -> mN_readdatavalid = 1 for exactly one cycle at T+1 with mN_readdata = mem_readdata.
REQ-017 SHALL track the return owner in a register (rd_valid, rd_owner); back-to-back reads from alternating requesters each return in order, one per cycle.
REQ-018 SHALL route mem_readdata only to the owning requester; the other requester's readdata holds 0 and readdatavalid 0.
REQ-019 SHALL treat a granted access with address >= MEM_WORDS as out-of-range: mem_chipselect 0, write dropped, read returns 32'h0 with readdatavalid at T+1.
REQ-020 SHALL set err_range on any out-of-range access and increment err_count, saturating at 16'hFFFF.
REQ-021 SHALL drive mem_* outputs to 0 when no grant occurs.

Reset
REQ-022 SHALL on reset clear prio, rd_valid, rd_owner, err_range, err_count; all readdatavalid 0, readdata 0.
REQ-023 SHALL cancel any read return pending at reset; no readdatavalid in the cycle after reset deasserts.
REQ-024 SHALL, while reset is high, drive mem_chipselect 0, mem_write 0, and mN_waitrequest 1 for active requesters.

Structure
REQ-025 SHALL place MEM_WORDS default, ADDR_W default and requester index constants (REQ_M0=0, REQ_M1=1) in a shared package nios_system_com_ocmem_pkg.
REQ-026 SHALL implement the grant logic as one sub-module nios_system_com_rr_arb2 (2-input round-robin, req[1:0] -> gnt[1:0], prio register); the rest stays flat.
REQ-027 SHALL contain no storage other than prio, read-return tracking, readdata registers and error counters.

Verification
REQ-028 Single write: m0 write addr 10'h005, data 32'hDEADBEEF, be 4'hF; then m0 read 10'h005 -> readdatavalid at T+1, readdata 32'hDEADBEEF, waitrequest never 1.
REQ-029 Contention: m0 and m1 both read every cycle for 6 cycles -> grants alternate m0,m1,m0,...; each requester gets exactly 3 readdatavalid pulses, in order.
REQ-030 Byte enables: write 32'h11223344 be 4'hF, then 32'hAABBCCDD be 4'b0101 to 10'h010 -> read returns 32'h11BB33DD.
REQ-031 Out-of-range: m1 write 10'd768 then read 10'd1023 -> mem_chipselect 0 both cycles, read returns 32'h0, err_range 1, err_count 2.
REQ-032 Reset mid-operation: m0 read issued at T, reset high at T+1 -> no readdatavalid after reset, prio 0, err_count 0.
REQ-033 Simultaneous read+write: m0 read=1, write=1, addr 10'h020, data 32'h5A5A5A5A -> memory written, no readdatavalid; subsequent read returns 32'h5A5A5A5A.
